// File: rtl/udp_tx_pkg.sv
// ============================================================================
//  Package     : udp_tx_pkg
//  Description : Shared types and constants for the UDP transmit framer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package udp_tx_pkg;

    // UDP header is always 8 bytes: src port, dst port, length, checksum
    localparam int          UDP_HDR_LEN       = 8;
    // Checksum transmission is disabled, so the field is sent as zero
    localparam logic [15:0] UDP_CHECKSUM_NONE = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ_IP  = 3'd1,
        ST_HEADER  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

endpackage

`default_nettype wire

// File: rtl/udp_tx_framer_if.sv
// ============================================================================
//  Interface   : udp_tx_framer_if
//  Description : Producer handshake and IP-layer byte stream of the UDP
//                transmit framer. The master modport is the framer's view.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface udp_tx_framer_if;

    // Producer side
    logic        udp_tx_request;
    logic [15:0] udp_tx_length;
    logic [7:0]  port_ID;
    logic [7:0]  udp_tx_data;
    logic [15:0] pc_udp_port;
    logic        udp_tx_enable;
    logic        udp_tx_active;

    // IP / MAC transmit side
    logic        ip_tx_request;
    logic [15:0] ip_tx_length;
    logic        ip_tx_grant;
    logic [7:0]  ip_tx_data;
    logic        ip_tx_valid;
    logic        ip_tx_last;
    logic        ip_tx_ready;

    modport master (
        input  udp_tx_request, udp_tx_length, port_ID, udp_tx_data, pc_udp_port,
        output udp_tx_enable, udp_tx_active,
        output ip_tx_request, ip_tx_length, ip_tx_data, ip_tx_valid, ip_tx_last,
        input  ip_tx_grant, ip_tx_ready
    );

    modport slave (
        output udp_tx_request, udp_tx_length, port_ID, udp_tx_data, pc_udp_port,
        input  udp_tx_enable, udp_tx_active,
        input  ip_tx_request, ip_tx_length, ip_tx_data, ip_tx_valid, ip_tx_last,
        output ip_tx_grant, ip_tx_ready
    );

endinterface

`default_nettype wire

// File: rtl/udp_hdr_gen.sv
// ============================================================================
//  Module      : udp_hdr_gen
//  Description : Holds the per-datagram header fields and presents the UDP
//                header byte selected by a 3-bit index (MSB first).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_hdr_gen
    import udp_tx_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        load_i,
    input  logic [15:0] src_i,
    input  logic [15:0] dst_i,
    input  logic [15:0] len_i,
    input  logic [2:0]  idx_i,
    output logic [7:0]  hdr_byte_o,
    output logic        hdr_last_o,
    output logic [15:0] udp_len_o
);

    logic [15:0] src_q, src_d;
    logic [15:0] dst_q, dst_d;
    logic [15:0] ulen_q, ulen_d;

    // Capture the header fields when a new datagram is accepted
    always_comb begin
        src_d  = src_q;
        dst_d  = dst_q;
        ulen_d = ulen_q;
        if (load_i) begin
            src_d  = src_i;
            dst_d  = dst_i;
            ulen_d = len_i + 16'(UDP_HDR_LEN);
        end
    end

    // Header field registers
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            src_q  <= 16'h0000;
            dst_q  <= 16'h0000;
            ulen_q <= 16'h0000;
        end else begin
            src_q  <= src_d;
            dst_q  <= dst_d;
            ulen_q <= ulen_d;
        end
    end

    // Byte selection, network order (high byte first)
    always_comb begin
        case (idx_i)
            3'd0:    hdr_byte_o = src_q[15:8];
            3'd1:    hdr_byte_o = src_q[7:0];
            3'd2:    hdr_byte_o = dst_q[15:8];
            3'd3:    hdr_byte_o = dst_q[7:0];
            3'd4:    hdr_byte_o = ulen_q[15:8];
            3'd5:    hdr_byte_o = ulen_q[7:0];
            3'd6:    hdr_byte_o = UDP_CHECKSUM_NONE[15:8];
            3'd7:    hdr_byte_o = UDP_CHECKSUM_NONE[7:0];
            default: hdr_byte_o = 8'h00;
        endcase
    end

    assign hdr_last_o = (idx_i == 3'd7);
    assign udp_len_o  = ulen_q;

endmodule

`default_nettype wire

// File: rtl/udp_tx_framer.sv
// ============================================================================
//  Module      : udp_tx_framer
//  Description : Accepts one UDP payload at a time from the producer,
//                prepends the 8-byte UDP header and streams the datagram to
//                the IP layer with ready/valid flow control. An abandoned
//                payload is padded with zeros up to the announced length.
//                Optional macro UDP_TX_STATS_EN adds pkt_count/abort_count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module udp_tx_framer
    import udp_tx_pkg::*;
#(
    parameter logic [15:0] BASE_PORT = 16'd1024
`ifdef UDP_TX_STATS_EN
    ,
    parameter int          STATS_W   = 32
`endif
)(
    input  logic               tx_clock,
    input  logic               reset_n,
    udp_tx_framer_if.master    bus
`ifdef UDP_TX_STATS_EN
    ,
    output logic [STATS_W-1:0] pkt_count,
    output logic [STATS_W-1:0] abort_count
`endif
);

    state_e      state_q, state_d;
    logic [15:0] len_q, len_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        abort_q, abort_d;
    logic        enable_q, enable_d;

    logic        hdr_load_w;
    logic [7:0]  hdr_byte_w;
    logic        hdr_last_w;
    logic [15:0] udp_len_w;
    logic [15:0] src_w;
    logic        pad_w;
    logic        pay_last_w;

    assign src_w      = BASE_PORT + {8'h00, bus.port_ID};
    // Once the producer lets go of the request the rest of the payload is zeros
    assign pad_w      = abort_q | ~bus.udp_tx_request;
    assign pay_last_w = (cnt_q == (len_q - 16'd1));

    udp_hdr_gen u_hdr_gen (
        .clk_i      (tx_clock),
        .rst_n_i    (reset_n),
        .load_i     (hdr_load_w),
        .src_i      (src_w),
        .dst_i      (bus.pc_udp_port),
        .len_i      (bus.udp_tx_length),
        .idx_i      (idx_q),
        .hdr_byte_o (hdr_byte_w),
        .hdr_last_o (hdr_last_w),
        .udp_len_o  (udp_len_w)
    );

    // Next-state and output decode of the framing FSM
    always_comb begin
        state_d           = state_q;
        len_d             = len_q;
        idx_d             = idx_q;
        cnt_d             = cnt_q;
        abort_d           = abort_q;
        enable_d          = 1'b0;
        hdr_load_w        = 1'b0;
        bus.ip_tx_request = 1'b0;
        bus.ip_tx_valid   = 1'b0;
        bus.ip_tx_data    = 8'h00;
        bus.ip_tx_last    = 1'b0;
        bus.udp_tx_active = 1'b0;
        bus.ip_tx_length  = (state_q == ST_IDLE) ? 16'h0000 : udp_len_w;

        case (state_q)
            ST_IDLE: begin
                if (bus.udp_tx_request) begin
                    state_d    = ST_REQ_IP;
                    len_d      = bus.udp_tx_length;
                    hdr_load_w = 1'b1;
                    idx_d      = 3'd0;
                    cnt_d      = 16'h0000;
                    abort_d    = 1'b0;
                end
            end

            ST_REQ_IP: begin
                bus.ip_tx_request = 1'b1;
                if (bus.ip_tx_grant) begin
                    state_d  = ST_HEADER;
                    enable_d = 1'b1;
                end
            end

            ST_HEADER: begin
                bus.ip_tx_valid = 1'b1;
                bus.ip_tx_data  = hdr_byte_w;
                bus.ip_tx_last  = hdr_last_w & (len_q == 16'h0000);
                if (bus.ip_tx_ready) begin
                    idx_d = idx_q + 3'd1;
                    if (hdr_last_w) begin
                        state_d = (len_q != 16'h0000) ? ST_PAYLOAD : ST_DONE;
                    end
                end
            end

            ST_PAYLOAD: begin
                bus.ip_tx_valid   = 1'b1;
                bus.ip_tx_data    = pad_w ? 8'h00 : bus.udp_tx_data;
                bus.ip_tx_last    = pay_last_w;
                bus.udp_tx_active = bus.ip_tx_ready & ~pad_w;
                if (!bus.udp_tx_request) begin
                    abort_d = 1'b1;
                end
                if (bus.ip_tx_ready) begin
                    cnt_d = cnt_q + 16'd1;
                    if (pay_last_w) begin
                        state_d = ST_DONE;
                    end
                end
            end

            ST_DONE: begin
                if (!bus.udp_tx_request) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and datapath registers
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            len_q    <= 16'h0000;
            idx_q    <= 3'd0;
            cnt_q    <= 16'h0000;
            abort_q  <= 1'b0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            abort_q  <= abort_d;
            enable_q <= enable_d;
        end
    end

    assign bus.udp_tx_enable = enable_q;

`ifdef UDP_TX_STATS_EN
    logic [STATS_W-1:0] pkt_cnt_q;
    logic [STATS_W-1:0] abort_cnt_q;
    logic               pkt_evt_w;
    logic               abort_evt_w;

    assign pkt_evt_w   = (state_d == ST_DONE) && (state_q != ST_DONE);
    assign abort_evt_w = (state_q == ST_PAYLOAD) && !bus.udp_tx_request && !abort_q;

    // Completed-datagram and abandoned-payload counters, free-running wrap
    always_ff @(posedge tx_clock or negedge reset_n) begin
        if (!reset_n) begin
            pkt_cnt_q   <= '0;
            abort_cnt_q <= '0;
        end else begin
            if (pkt_evt_w) begin
                pkt_cnt_q <= pkt_cnt_q + STATS_W'(1);
            end
            if (abort_evt_w) begin
                abort_cnt_q <= abort_cnt_q + STATS_W'(1);
            end
        end
    end

    assign pkt_count   = pkt_cnt_q;
    assign abort_count = abort_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_udp_tx_framer.sv
// ============================================================================
//  Module      : tb_udp_tx_framer
//  Description : Self-checking bench for udp_tx_framer. Expected datagrams
//                are built as byte queues from the header layout and the
//                random payload, and compared to the accepted byte stream.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_udp_tx_framer;

    localparam int BASE   = 1024;
    localparam int BUDGET = 5000;

    logic tx_clock = 1'b0;
    logic reset_n  = 1'b0;

    udp_tx_framer_if bus ();

`ifdef UDP_TX_STATS_EN
    logic [31:0] pkt_count;
    logic [31:0] abort_count;
`endif

    udp_tx_framer dut (
        .tx_clock    (tx_clock),
        .reset_n     (reset_n),
        .bus         (bus)
`ifdef UDP_TX_STATS_EN
        ,
        .pkt_count   (pkt_count),
        .abort_count (abort_count)
`endif
    );

    always #5 tx_clock = ~tx_clock;

    int n_checks  = 0;
    int n_fail    = 0;
    int exp_pkt   = 0;
    int exp_abort = 0;

    task automatic drive_idle();
        bus.udp_tx_request = 1'b0;
        bus.udp_tx_length  = 16'h0000;
        bus.port_ID        = 8'h00;
        bus.udp_tx_data    = 8'h00;
        bus.pc_udp_port    = 16'h0000;
        bus.ip_tx_grant    = 1'b0;
        bus.ip_tx_ready    = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        logic [28:0] outs;
        outs = {bus.udp_tx_enable, bus.udp_tx_active, bus.ip_tx_request, bus.ip_tx_length,
                bus.ip_tx_data, bus.ip_tx_valid, bus.ip_tx_last};
        n_checks++;
        if (outs !== 29'd0) begin
            n_fail++;
            $display("FAIL %s outputs: got %h expected 0", tag, outs);
        end
`ifdef UDP_TX_STATS_EN
        n_checks++;
        if (pkt_count !== 32'd0 || abort_count !== 32'd0) begin
            n_fail++;
            $display("FAIL %s stats: got pkt=%0d abort=%0d expected 0/0", tag, pkt_count, abort_count);
        end
`endif
    endtask

    task automatic apply_reset();
        @(negedge tx_clock);
        drive_idle();
        reset_n = 1'b0;
        @(negedge tx_clock);
        reset_n   = 1'b1;
        exp_pkt   = 0;
        exp_abort = 0;
    endtask

    // Drives one datagram through the framer and checks it against a byte-queue model.
    // ready_mode: 0 always high, 1 toggling, 2 random. abort_after < 0 means no abort.
    task automatic run_packet(input string name, input logic [7:0] pid, input logic [15:0] dst,
                              input int len, input int ready_mode, input int abort_after,
                              input int grant_delay);
        logic [7:0]  pay[$];
        logic [7:0]  exp_q[$];
        logic [15:0] src;
        logic [15:0] ulen;
        logic [7:0]  prev_data;
        logic        prev_last;
        bit          done, aborted, prev_stall;
        int ptr, nbytes, en_cnt, act_cnt, bad_act, req_cyc, first_req, last_idx, last_cnt, cyc, exp_act;

        done = 0; aborted = 0; prev_stall = 0; prev_data = 8'h00; prev_last = 1'b0;
        ptr = 0; nbytes = 0; en_cnt = 0; act_cnt = 0; bad_act = 0; req_cyc = 0;
        first_req = -1; last_idx = -1; last_cnt = 0; cyc = 0;

        src  = 16'(BASE + int'(pid));
        ulen = 16'(len + 8);
        exp_q.push_back(src[15:8]);  exp_q.push_back(src[7:0]);
        exp_q.push_back(dst[15:8]);  exp_q.push_back(dst[7:0]);
        exp_q.push_back(ulen[15:8]); exp_q.push_back(ulen[7:0]);
        exp_q.push_back(8'h00);      exp_q.push_back(8'h00);
        for (int i = 0; i < len; i++) begin
            pay.push_back(8'($urandom));
            exp_q.push_back((abort_after >= 0 && i >= abort_after) ? 8'h00 : pay[i]);
        end
        exp_act = (abort_after >= 0) ? abort_after : len;

        @(negedge tx_clock);
        bus.udp_tx_request = 1'b1;
        bus.udp_tx_length  = 16'(len);
        bus.port_ID        = pid;
        bus.pc_udp_port    = dst;

        while (!done && cyc < BUDGET) begin
            if (abort_after >= 0 && nbytes >= 8 && ptr >= abort_after) aborted = 1;
            bus.udp_tx_request = !aborted;
            bus.udp_tx_data    = (!aborted && ptr < len) ? pay[ptr] : 8'($urandom);
            case (ready_mode)
                0:       bus.ip_tx_ready = 1'b1;
                1:       bus.ip_tx_ready = ((cyc % 2) == 1);
                default: bus.ip_tx_ready = ($urandom_range(0, 3) != 0);
            endcase
            bus.ip_tx_grant = 1'b0;
            #1;
            if (bus.ip_tx_request) begin
                req_cyc++;
                if (first_req < 0) first_req = cyc;
                if (req_cyc >= grant_delay) bus.ip_tx_grant = 1'b1;
                n_checks++;
                if (bus.ip_tx_length !== ulen) begin
                    n_fail++;
                    $display("FAIL %s ip_tx_length: got %0d expected %0d", name, bus.ip_tx_length, ulen);
                end
            end
            #1;
            if (prev_stall) begin
                n_checks++;
                if (bus.ip_tx_valid !== 1'b1 || bus.ip_tx_data !== prev_data || bus.ip_tx_last !== prev_last) begin
                    n_fail++;
                    $display("FAIL %s hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b", name,
                             bus.ip_tx_valid, bus.ip_tx_data, bus.ip_tx_last, prev_data, prev_last);
                end
            end
            if (bus.udp_tx_enable) en_cnt++;
            if (bus.udp_tx_active) begin
                act_cnt++;
                if (!bus.ip_tx_ready || !bus.udp_tx_request) bad_act++;
            end
            if (bus.ip_tx_valid && bus.ip_tx_ready) begin
                n_checks++;
                if (nbytes >= exp_q.size()) begin
                    n_fail++;
                    $display("FAIL %s extra_byte %0d: got %h expected none", name, nbytes, bus.ip_tx_data);
                end else if (bus.ip_tx_data !== exp_q[nbytes]) begin
                    n_fail++;
                    $display("FAIL %s byte %0d: got %h expected %h", name, nbytes, bus.ip_tx_data, exp_q[nbytes]);
                end
                if (bus.ip_tx_last) begin
                    last_idx = nbytes;
                    last_cnt++;
                    done = 1;
                end
                nbytes++;
            end
            prev_stall = bus.ip_tx_valid && !bus.ip_tx_ready;
            prev_data  = bus.ip_tx_data;
            prev_last  = bus.ip_tx_last;
            if (bus.udp_tx_active) ptr++;
            cyc++;
            @(negedge tx_clock);
        end
        bus.ip_tx_grant = 1'b0;

        n_checks++;
        if (!done) begin
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes after %0d cycles expected last byte", name, nbytes, cyc);
        end
        n_checks++;
        if (nbytes != exp_q.size() || last_idx != exp_q.size() - 1 || last_cnt != 1) begin
            n_fail++;
            $display("FAIL %s length/last: got bytes=%0d last_at=%0d last_cnt=%0d expected bytes=%0d last_at=%0d",
                     name, nbytes, last_idx, last_cnt, exp_q.size(), exp_q.size() - 1);
        end
        n_checks++;
        if (en_cnt != 1) begin
            n_fail++;
            $display("FAIL %s enable_pulses: got %0d expected 1", name, en_cnt);
        end
        n_checks++;
        if (act_cnt != exp_act || bad_act != 0) begin
            n_fail++;
            $display("FAIL %s active: got %0d (bad %0d) expected %0d (bad 0)", name, act_cnt, bad_act, exp_act);
        end
        n_checks++;
        if (req_cyc != grant_delay || first_req != 1) begin
            n_fail++;
            $display("FAIL %s ip_request: got %0d cycles starting at %0d expected %0d starting at 1",
                     name, req_cyc, first_req, grant_delay);
        end

        // Now in the post-datagram idle cycle
        bus.udp_tx_request = 1'b0;
        exp_pkt++;
        if (abort_after >= 0) exp_abort++;
        #1;
        n_checks++;
        if (bus.ip_tx_valid !== 1'b0 || bus.ip_tx_request !== 1'b0 || bus.udp_tx_active !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_idle: got v=%b req=%b act=%b expected 0/0/0", name,
                     bus.ip_tx_valid, bus.ip_tx_request, bus.udp_tx_active);
        end
`ifdef UDP_TX_STATS_EN
        n_checks++;
        if (pkt_count !== 32'(exp_pkt) || abort_count !== 32'(exp_abort)) begin
            n_fail++;
            $display("FAIL %s stats: got pkt=%0d abort=%0d expected pkt=%0d abort=%0d", name,
                     pkt_count, abort_count, exp_pkt, exp_abort);
        end
`endif
        @(negedge tx_clock);
    endtask

    task automatic test_reset();
        drive_idle();
        reset_n = 1'b0;
        repeat (3) @(negedge tx_clock);
        #1;
        check_all_zero("reset_hold");
        @(negedge tx_clock);
        reset_n = 1'b1;
        @(negedge tx_clock);
        #1;
        check_all_zero("reset_release_idle");
        exp_pkt   = 0;
        exp_abort = 0;
    endtask

    task automatic test_basic();
        run_packet("basic_len60", 8'd11, 16'h0400, 60, 0, -1, 1);
    endtask

    task automatic test_ready_toggle();
        run_packet("toggle_len60", 8'd11, 16'h0400, 60, 1, -1, 1);
    endtask

    task automatic test_zero_length();
        run_packet("zero_len", 8'd11, 16'h0400, 0, 0, -1, 1);
    endtask

    task automatic test_abort();
        run_packet("abort_1028", 8'(($urandom)), 16'($urandom), 1028, 0, 10, 1);
    endtask

    task automatic test_reset_mid_packet();
        int acc;
        int cyc;
        logic [15:0] dst;
        acc = 0;
        cyc = 0;
        dst = 16'hA5C3;
        @(negedge tx_clock);
        bus.udp_tx_request = 1'b1;
        bus.udp_tx_length  = 16'd40;
        bus.port_ID        = 8'd7;
        bus.pc_udp_port    = dst;
        bus.ip_tx_ready    = 1'b1;
        while (acc < 3 && cyc < 100) begin
            bus.ip_tx_grant = 1'b0;
            #1;
            bus.ip_tx_grant = bus.ip_tx_request;
            #1;
            if (bus.ip_tx_valid && bus.ip_tx_ready) acc++;
            cyc++;
            @(negedge tx_clock);
        end
        bus.ip_tx_grant = 1'b0;
        #1;
        n_checks++;
        if (acc != 3 || bus.ip_tx_valid !== 1'b1 || bus.ip_tx_data !== dst[7:0]) begin
            n_fail++;
            $display("FAIL mid_reset header_byte3: got acc=%0d v=%b d=%h expected acc=3 v=1 d=%h",
                     acc, bus.ip_tx_valid, bus.ip_tx_data, dst[7:0]);
        end
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset_async");
        drive_idle();
        @(negedge tx_clock);
        reset_n   = 1'b1;
        exp_pkt   = 0;
        exp_abort = 0;
        @(negedge tx_clock);
        #1;
        check_all_zero("mid_reset_after");
        run_packet("after_reset_132", 8'($urandom), 16'($urandom), 132, 0, -1, 1);
    endtask

    task automatic test_back_to_back();
        apply_reset();
        run_packet("b2b_first", 8'($urandom), 16'($urandom), 20, 0, -1, 5);
        run_packet("b2b_second", 8'($urandom), 16'($urandom), 33, 0, -1, 5);
`ifdef UDP_TX_STATS_EN
        n_checks++;
        if (pkt_count !== 32'd2) begin
            n_fail++;
            $display("FAIL b2b pkt_count: got %0d expected 2", pkt_count);
        end
`endif
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++) begin
            int len;
            int ab;
            len = int'($urandom_range(0, 40));
            ab  = (len > 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
            run_packet($sformatf("random_%0d", k), 8'($urandom), 16'($urandom), len, 2, ab,
                       int'($urandom_range(1, 4)));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_toggle();
        test_zero_length();
        test_abort();
        test_reset_mid_packet();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire
